tmac_pkt_sched: RTL and testbench

- Transmit-side consumer of the CPU packet-descriptor flags held in the 256x1 packet-complete RAM and the matching length RAM.
- Runs in the clk125m domain on port B of those RAMs.
- Scans entries round-robin and hands each CPU-completed packet (flag=1) to the TMAC transmit engine through a req/ack/done handshake.
- Reports consumption back to the CPU side by writing the per-entry RDI bit (rdi_buf write port into the MPI).

---
 rtl/tmac_pkt_sched_pkg.sv | 19 +
 rtl/tmac_pkt_sched_if.sv | 30 +++
 rtl/tmac_consumed_map.sv | 31 +++
 rtl/tmac_pkt_sched.sv | 149 ++++++++++++++
 tb/tb_tmac_pkt_sched.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmac_pkt_sched_pkg.sv
// Shared definitions for the TMAC packet scheduler: default widths, legal length window
// and the scheduler FSM state encoding.
package tmac_pkt_sched_pkg;

  localparam int unsigned DefAddrW  = 8;
  localparam int unsigned DefLenW   = 10;
  localparam int unsigned DefMinLen = 64;
  localparam int unsigned DefMaxLen = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StReq,
    StWait,
    StRdi
  } sched_state_e;

endpackage

// File: rtl/tmac_pkt_sched_if.sv
// Request/ack/done handshake between the packet scheduler (master) and the TMAC transmit
// engine (slave).
interface tmac_pkt_sched_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 10
);

  logic              tx_req;
  logic [ADDR_W-1:0] tx_addr;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_ack;
  logic              tx_done;

  modport master (
    output tx_req,
    output tx_addr,
    output tx_len,
    input  tx_ack,
    input  tx_done
  );

  modport slave (
    input  tx_req,
    input  tx_addr,
    input  tx_len,
    output tx_ack,
    output tx_done
  );

endinterface

// File: rtl/tmac_consumed_map.sv
// One bit per descriptor entry recording that the scheduler has already handed the entry
// off. Single address port with set/clear strobes and a combinational read.
module tmac_consumed_map #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              set,
  input  logic              clr,
  output logic              rd
);

  localparam int unsigned Entries = 2 ** ADDR_W;

  logic [Entries-1:0] map_q;

  // Bitmap update; set wins over clear (they are never requested together).
  always_ff @(posedge clk) begin
    if (rst) begin
      map_q <= '0;
    end else if (set) begin
      map_q[addr] <= 1'b1;
    end else if (clr) begin
      map_q[addr] <= 1'b0;
    end
  end

  assign rd = map_q[addr];

endmodule

// File: rtl/tmac_pkt_sched.sv
// TMAC transmit packet scheduler. Scans the packet-complete flag RAM round-robin, issues
// each newly completed descriptor to the transmit engine and reports consumption through
// the RDI bitmap write port.
// Optional build macro: TMAC_LEN_CHECK_EN drops descriptors whose length is outside
// [MIN_LEN, MAX_LEN] and pulses len_err instead of transmitting them.
module tmac_pkt_sched
  import tmac_pkt_sched_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned LEN_W   = DefLenW,
  parameter int unsigned MIN_LEN = DefMinLen,
  parameter int unsigned MAX_LEN = DefMaxLen
) (
  input  logic                    clk125m,
  input  logic                    rst,
  input  logic                    sched_en,
  output logic [ADDR_W-1:0]       length_buf_raddr,
  input  logic                    pkt_com_rdata,
  input  logic [LEN_W-1:0]        tpkt_length_rdata,
  tmac_pkt_sched_if.master        tx,
  output logic                    rdi_buf_wen,
  output logic [ADDR_W-1:0]       rdi_buf_waddr,
  output logic                    rdi_buf_wdata,
  output logic                    len_err
);

`ifdef TMAC_LEN_CHECK_EN
  localparam bit LenCheckEn = 1'b1;
`else
  localparam bit LenCheckEn = 1'b0;
`endif

  sched_state_e      state;
  logic [ADDR_W-1:0] ptr;
  logic              consumed;
  logic              take;
  logic              clr;
  logic              set;
  logic              len_bad;

  // The RAM address is the scan pointer itself, so it is stable through S_ADDR and S_DATA.
  assign length_buf_raddr = ptr;

  // New work: CPU flagged the entry and we have not handed it off since it was last seen at 0.
  assign take = pkt_com_rdata && !consumed;
  // CPU reclaimed a consumed entry.
  assign clr  = (state == StData) && !pkt_com_rdata && consumed;
  assign set  = (state == StRdi);

  assign len_bad = LenCheckEn &&
                   ((tpkt_length_rdata < LEN_W'(MIN_LEN)) ||
                    (tpkt_length_rdata > LEN_W'(MAX_LEN)));

  tmac_consumed_map #(
    .ADDR_W (ADDR_W)
  ) u_consumed_map (
    .clk  (clk125m),
    .rst  (rst),
    .addr (ptr),
    .set  (set),
    .clr  (clr),
    .rd   (consumed)
  );

  // Scheduler FSM with registered outputs; write/error strobes default low each cycle.
  always_ff @(posedge clk125m) begin
    if (rst) begin
      state         <= StIdle;
      ptr           <= '0;
      tx.tx_req     <= 1'b0;
      tx.tx_addr    <= '0;
      tx.tx_len     <= '0;
      rdi_buf_wen   <= 1'b0;
      rdi_buf_waddr <= '0;
      rdi_buf_wdata <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      rdi_buf_wen <= 1'b0;
      len_err     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (sched_en) begin
            state <= StAddr;
          end
        end
        StAddr: begin
          state <= StData;
        end
        StData: begin
          if (take && sched_en) begin
            if (len_bad) begin
              // Illegal length: skip the engine, report it consumed so the CPU reclaims it.
              len_err       <= 1'b1;
              rdi_buf_wen   <= 1'b1;
              rdi_buf_waddr <= ptr;
              rdi_buf_wdata <= 1'b1;
              state         <= StRdi;
            end else begin
              tx.tx_req  <= 1'b1;
              tx.tx_addr <= ptr;
              tx.tx_len  <= tpkt_length_rdata;
              state      <= StReq;
            end
          end else if (take) begin
            // Disabled before issue: keep ptr so this entry is the first one revisited.
            state <= StIdle;
          end else begin
            if (clr) begin
              rdi_buf_wen   <= 1'b1;
              rdi_buf_waddr <= ptr;
              rdi_buf_wdata <= 1'b0;
            end
            ptr   <= ptr + ADDR_W'(1);
            state <= sched_en ? StAddr : StIdle;
          end
        end
        StReq: begin
          if (tx.tx_ack) begin
            tx.tx_req <= 1'b0;
            if (tx.tx_done) begin
              rdi_buf_wen   <= 1'b1;
              rdi_buf_waddr <= ptr;
              rdi_buf_wdata <= 1'b1;
              state         <= StRdi;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (tx.tx_done) begin
            rdi_buf_wen   <= 1'b1;
            rdi_buf_waddr <= ptr;
            rdi_buf_wdata <= 1'b1;
            state         <= StRdi;
          end
        end
        StRdi: begin
          ptr   <= ptr + ADDR_W'(1);
          state <= sched_en ? StAddr : StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmac_pkt_sched.sv
// Scoreboard bench for tmac_pkt_sched: directed scenarios push expected requests, RDI
// writes and length errors; a monitor pops and compares whenever the DUT presents one.
module tb_tmac_pkt_sched;

  localparam int AW = 8;
  localparam int LW = 10;
  localparam int KReq = 0;
  localparam int KRdi = 1;
  localparam int KErr = 2;

  typedef struct {
    int kind;
    int addr;
    int val;
  } ev_t;

  logic          clk125m = 1'b0;
  logic          rst;
  logic          sched_en;
  logic [AW-1:0] length_buf_raddr;
  logic          pkt_com_rdata;
  logic [LW-1:0] tpkt_length_rdata;
  logic          rdi_buf_wen;
  logic [AW-1:0] rdi_buf_waddr;
  logic          rdi_buf_wdata;
  logic          len_err;

  tmac_pkt_sched_if #(.ADDR_W(AW), .LEN_W(LW)) tx_if ();

  tmac_pkt_sched dut (
    .clk125m           (clk125m),
    .rst               (rst),
    .sched_en          (sched_en),
    .length_buf_raddr  (length_buf_raddr),
    .pkt_com_rdata     (pkt_com_rdata),
    .tpkt_length_rdata (tpkt_length_rdata),
    .tx                (tx_if),
    .rdi_buf_wen       (rdi_buf_wen),
    .rdi_buf_waddr     (rdi_buf_waddr),
    .rdi_buf_wdata     (rdi_buf_wdata),
    .len_err           (len_err)
  );

  always #4 clk125m = ~clk125m;

  // Flag and length RAMs, port B: one-cycle read latency.
  logic          flag_mem [256];
  logic [LW-1:0] len_mem  [256];
  always @(posedge clk125m) begin
    pkt_com_rdata     <= flag_mem[length_buf_raddr];
    tpkt_length_rdata <= len_mem[length_buf_raddr];
  end

  int cyc = 0;
  always @(posedge clk125m) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  ack_dly = 2;
  int  done_dly = 10;
  int  ack_cyc = 0;
  int  rdi_cyc = 0;
  int  req_hi = 0;
  logic req_prev = 1'b0;

  function automatic void push(int kind, int addr, int val);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(int kind, int addr, int val);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got unexpected kind=%0d addr=%0d val=%0d at cycle %0d",
               kind, addr, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != addr || e.val != val) begin
        fails++;
        $display("FAIL event: got kind=%0d addr=%0d val=%0d, required kind=%0d addr=%0d val=%0d",
                 kind, addr, val, e.kind, e.addr, e.val);
      end
    end
  endfunction

  function automatic void check_val(string nm, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endfunction

  // Monitor: request rising edge, length error pulse, RDI write.
  always @(negedge clk125m) begin
    if (!rst) begin
      if (tx_if.tx_req && !req_prev) check_ev(KReq, int'(tx_if.tx_addr), int'(tx_if.tx_len));
      if (len_err) check_ev(KErr, 0, 0);
      if (rdi_buf_wen) begin
        check_ev(KRdi, int'(rdi_buf_waddr), int'(rdi_buf_wdata));
        rdi_cyc = cyc;
      end
      if (tx_if.tx_req) req_hi++;
    end
    req_prev = tx_if.tx_req;
  end

  // Transmit engine model; acts 2 time units after the edge, clear of the main driver.
  initial begin
    tx_if.tx_ack  = 1'b0;
    tx_if.tx_done = 1'b0;
    forever begin
      @(posedge clk125m); #2;
      if (tx_if.tx_req && !rst) begin
        for (int i = 0; i < ack_dly; i++) begin
          @(posedge clk125m); #2;
        end
        tx_if.tx_ack  = 1'b1;
        tx_if.tx_done = (done_dly == 0);
        ack_cyc = cyc;
        @(posedge clk125m); #2;
        tx_if.tx_ack  = 1'b0;
        tx_if.tx_done = 1'b0;
        if (done_dly > 0) begin
          for (int i = 1; i < done_dly && !rst; i++) begin
            @(posedge clk125m); #2;
          end
          if (!rst) begin
            tx_if.tx_done = 1'b1;
            @(posedge clk125m); #2;
            tx_if.tx_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic drain(int budget, string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk125m);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d events pending after %0d cycles, required 0", nm, exp_q.size(),
               budget);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(string nm);
    check_val({nm, " tx_req"}, int'(tx_if.tx_req), 0);
    check_val({nm, " tx_addr"}, int'(tx_if.tx_addr), 0);
    check_val({nm, " tx_len"}, int'(tx_if.tx_len), 0);
    check_val({nm, " raddr"}, int'(length_buf_raddr), 0);
    check_val({nm, " rdi_wen"}, int'(rdi_buf_wen), 0);
    check_val({nm, " rdi_waddr"}, int'(rdi_buf_waddr), 0);
    check_val({nm, " rdi_wdata"}, int'(rdi_buf_wdata), 0);
    check_val({nm, " len_err"}, int'(len_err), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      flag_mem[i] = 1'b0;
      len_mem[i]  = 10'd0;
    end
    rst      = 1'b1;
    sched_en = 1'b0;
    repeat (3) @(posedge clk125m);
    @(negedge clk125m);
    check_all_zero("reset");
    @(posedge clk125m); #1;
    rst      = 1'b0;
    sched_en = 1'b1;

    // Single flagged entry; never resent while its flag stays 1.
    ack_dly = 2; done_dly = 10;
    push(KReq, 5, 128);
    push(KRdi, 5, 1);
    len_mem[5] = 10'd128; flag_mem[5] = 1'b1;
    drain(700, "entry5 send");
    repeat (1100) @(posedge clk125m);

    // CPU reclaims entry 5, then re-posts it with a new length.
    push(KRdi, 5, 0);
    flag_mem[5] = 1'b0;
    drain(700, "entry5 reclaim");
    push(KReq, 5, 200);
    push(KRdi, 5, 1);
    len_mem[5] = 10'd200; flag_mem[5] = 1'b1;
    drain(700, "entry5 resend");

    // Pointer wrap: ptr sits just past 5, so 254, 255, then 0.
    ack_dly = 1; done_dly = 4;
    push(KReq, 254, 300); push(KRdi, 254, 1);
    push(KReq, 255, 400); push(KRdi, 255, 1);
    push(KReq, 0, 500);   push(KRdi, 0, 1);
    len_mem[254] = 10'd300; len_mem[255] = 10'd400; len_mem[0] = 10'd500;
    flag_mem[254] = 1'b1; flag_mem[255] = 1'b1; flag_mem[0] = 1'b1;
    drain(800, "wrap");

    // ack and done together: RDI write on the following cycle, single request.
    ack_dly = 1; done_dly = 0;
    req_hi = 0;
    push(KReq, 10, 64);
    push(KRdi, 10, 1);
    len_mem[10] = 10'd64; flag_mem[10] = 1'b1;
    drain(200, "ack+done");
    repeat (5) @(posedge clk125m);
    check_val("ack+done rdi latency", rdi_cyc - ack_cyc, 1);
    check_val("ack+done req cycles", req_hi, 2);

    // Reclaim everything consumed so far (scan resumes at 11).
    push(KRdi, 254, 0); push(KRdi, 255, 0); push(KRdi, 0, 0);
    push(KRdi, 5, 0);   push(KRdi, 10, 0);
    flag_mem[254] = 1'b0; flag_mem[255] = 1'b0; flag_mem[0] = 1'b0;
    flag_mem[5] = 1'b0; flag_mem[10] = 1'b0;
    drain(800, "bulk reclaim");

    // Reset while waiting for tx_done; the entry is sent again afterwards.
    ack_dly = 0; done_dly = 20;
    push(KReq, 20, 100);
    len_mem[20] = 10'd100; flag_mem[20] = 1'b1;
    drain(200, "entry20 pre-reset");
    repeat (3) @(posedge clk125m);
    #1 rst = 1'b1;
    @(posedge clk125m);
    @(negedge clk125m);
    check_all_zero("mid reset");
    done_dly = 3;
    push(KReq, 20, 100);
    push(KRdi, 20, 1);
    @(posedge clk125m); #1;
    rst = 1'b0;
    drain(300, "entry20 after reset");

    // Out-of-range length.
    ack_dly = 1; done_dly = 2;
`ifdef TMAC_LEN_CHECK_EN
    push(KErr, 0, 0);
    push(KRdi, 30, 1);
`else
    push(KReq, 30, 20);
    push(KRdi, 30, 1);
`endif
    len_mem[30] = 10'd20; flag_mem[30] = 1'b1;
    drain(300, "short length");
    repeat (600) @(posedge clk125m);

    check_val("leftover expected events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
